// File: rtl/xor_vector_checker.sv
// Drives the four 2-bit vectors onto an external XOR device, checks its response,
// and reports the error count, the first failing vector and a pass flag.
module xor_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_VEC    = IDX_W'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   v, v_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               a_n, b_n, pass_n;
    logic [ERR_W-1:0]   err_n;
    logic [IDX_W-1:0]   ff_n;
    logic               mismatch;

    // State register plus registered outputs; busy/done follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= '0;
            cnt        <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            state      <= state_n;
            v          <= v_n;
            cnt        <= cnt_n;
            dut_a      <= a_n;
            dut_b      <= b_n;
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            pass       <= pass_n;
            err_count  <= err_n;
            first_fail <= ff_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        v_n      = v;
        cnt_n    = cnt;
        a_n      = dut_a;
        b_n      = dut_b;
        pass_n   = pass;
        err_n    = err_count;
        ff_n     = first_fail;
        mismatch = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETTLE;
                    v_n     = '0;
                    cnt_n   = '0;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    err_n   = '0;
                    ff_n    = '0;
                    pass_n  = 1'b0;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == SETTLE_LAST) begin
                        state_n = CHECK;
                    end
                end
            end

            CHECK: begin
                if (abort) begin
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    mismatch = (dut_c != (dut_a ^ dut_b));
                    if (mismatch) begin
                        err_n = err_count + ERR_W'(1);
                        if (err_count == '0) begin
                            ff_n = v;
                        end
                    end
                    if ((mismatch && STOP_ON_FAIL) || (v == LAST_VEC)) begin
                        state_n = DONE;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        pass_n  = (err_n == '0);
                    end else begin
                        // Next vector is driven on the same edge that leaves CHECK.
                        v_n     = v + IDX_W'(1);
                        a_n     = v_n[1];
                        b_n     = v_n[0];
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                a_n     = 1'b0;
                b_n     = 1'b0;
                if (abort) begin
                    pass_n = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
                a_n     = 1'b0;
                b_n     = 1'b0;
            end
        endcase
    end

endmodule
